collatz_sched: RTL and testbench

Round-robin scheduler that shares one Collatz iterator among `N_REQ` requesters. Each requester submits a 32-bit start value. The block arbitrates, launches the iterator, and counts the terms in the sequence. It then returns a 16-bit term count, tagged with the requester id, on a common response bus. It sits between the host-side request ports and the `collatz` iterator instance, which it sequences through `cgo`/`cn`/`cdone`.

---
 rtl/collatz_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/collatz_sched.sv | 116 +++++++++++
 tb/tb_collatz_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared types and widths for the Collatz request scheduler.
package collatz_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned N_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    GO,
    RUN,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [ID_BITS-1:0] ptr,
  output logic [ID_BITS-1:0] sel,
  output logic               any
);

  localparam int unsigned IW = ID_BITS + 1;

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + IW'(k);
      if (idx >= IW'(N_REQ)) begin
        idx = idx - IW'(N_REQ);
      end
      if (req_valid[idx[ID_BITS-1:0]]) begin
        sel = idx[ID_BITS-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collatz_sched.sv
// Round-robin scheduler sharing one external Collatz iterator among N_REQ requesters;
// returns the sequence term count tagged with the requester id.
module collatz_sched
  import collatz_pkg::*;
#(
  parameter int unsigned      N_REQ    = 4,
  parameter int unsigned      ID_BITS  = 2,
  parameter logic [CNT_W-1:0] MAX_ITER = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_W*N_REQ-1:0]   req_n,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_BITS-1:0]     rsp_id,
  output logic [CNT_W-1:0]       rsp_count,
  output logic                   rsp_ovf,
  output logic                   busy,
  output logic                   cgo,
  output logic [N_W-1:0]         cn,
  input  logic                   cdone
);

  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(N_REQ - 1);

  state_t             state;
  logic [ID_BITS-1:0] ptr;
  logic [ID_BITS-1:0] id_q;
  logic [ID_BITS-1:0] sel;
  logic               any;
  logic [CNT_W-1:0]   cnt;
  logic [N_W-1:0]     req_words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign req_words[i] = req_n[N_W*i +: N_W];
  end

  rr_arbiter #(
    .N_REQ   (N_REQ),
    .ID_BITS (ID_BITS)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .sel       (sel),
    .any       (any)
  );

  // Acceptance strobe is combinational so a requester sees it in the same cycle.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any) begin
      req_ready[sel] = 1'b1;
    end
  end

  // cn doubles as the latched start value; cgo is raised on accept so it is high during GO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      cnt       <= '0;
      cgo       <= 1'b0;
      cn        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
      rsp_ovf   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cgo       <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            id_q  <= sel;
            cn    <= req_words[sel];
            cgo   <= 1'b1;
            busy  <= 1'b1;
            state <= GO;
          end
        end
        GO: begin
          cnt   <= CNT_W'(1);
          state <= RUN;
        end
        RUN: begin
          // Limit check comes before the increment, so cnt never wraps.
          if (cdone) begin
            rsp_count <= cnt;
            rsp_ovf   <= 1'b0;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == MAX_ITER) begin
            rsp_count <= MAX_ITER;
            rsp_ovf   <= 1'b1;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          ptr   <= (id_q == LAST_ID) ? '0 : id_q + ID_BITS'(1);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_sched.sv
// Bench for collatz_sched: two instances (default limit and limit 100) checked every
// cycle against a transaction-timeline model, plus literal expectations on responses.
`timescale 1ns/1ps
module tb_collatz_sched;

  localparam int NL = 2;
  localparam int NR = 4;

  typedef struct {
    int id;
    int cnt;
    int ov;
    int lat;
  } rsp_rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid [NL];
  logic [32*NR-1:0] req_n     [NL];
  logic [NR-1:0]    req_ready [NL];
  logic [1:0]       rsp_id    [NL];
  logic [15:0]      rsp_count [NL];
  logic [31:0]      cn        [NL];
  logic [NL-1:0]    rsp_valid;
  logic [NL-1:0]    rsp_ovf;
  logic [NL-1:0]    busy;
  logic [NL-1:0]    cgo;
  logic [NL-1:0]    cdone;

  collatz_sched #(.N_REQ(4), .ID_BITS(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_n(req_n[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
    .rsp_count(rsp_count[0]), .rsp_ovf(rsp_ovf[0]), .busy(busy[0]),
    .cgo(cgo[0]), .cn(cn[0]), .cdone(cdone[0])
  );

  collatz_sched #(.N_REQ(4), .ID_BITS(2), .MAX_ITER(16'd100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_n(req_n[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
    .rsp_count(rsp_count[1]), .rsp_ovf(rsp_ovf[1]), .busy(busy[1]),
    .cgo(cgo[1]), .cn(cn[1]), .cdone(cdone[1])
  );

  // Iterator stand-in: loads on cgo, steps once per clock, parks on 1 (or 0).
  for (genvar g = 0; g < NL; g++) begin : g_iter
    logic [31:0] it_q;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) it_q <= '0;
      else if (cgo[g]) it_q <= cn[g];
      else if (it_q == 32'd1 || it_q == 32'd0) it_q <= it_q;
      else if (it_q[0]) it_q <= 3 * it_q + 1;
      else it_q <= it_q >> 1;
    end
    assign cdone[g] = (it_q == 32'd1);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit allow_drop = 1'b0;

  bit          m_busy [NL];
  int          m_ptr  [NL];
  int          t_acc  [NL];
  int          m_L    [NL];
  int          m_id   [NL];
  bit          m_ovf  [NL];
  logic [31:0] m_n    [NL];
  logic [31:0] e_cn   [NL];
  logic [31:0] e_id   [NL];
  logic [31:0] e_cnt  [NL];
  logic [31:0] e_ovf  [NL];
  bit          acc_flag [NL*NR];
  int unsigned pend     [NL*NR][$];
  rsp_rec_t    lg       [NL][$];

  function automatic int lane_max(input int k);
    return (k == 0) ? 65535 : 100;
  endfunction

  // Number of terms from n down to 1 inclusive, capped at mx (n=0 never terminates).
  function automatic int clen(input int unsigned n0, input int mx, output bit ov);
    int unsigned n;
    int t;
    n  = n0;
    t  = 1;
    ov = 1'b0;
    if (n == 0) begin
      ov = 1'b1;
      return mx;
    end
    while (n != 1 && t < mx) begin
      n = n[0] ? 3 * n + 1 : n / 2;
      t++;
    end
    if (n == 1) return t;
    ov = 1'b1;
    return mx;
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int j = 0; j < NR; j++) begin
      if (v[(p + j) % NR]) return (p + j) % NR;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d cyc %0d: got %0d expected %0d", nm, k, cyc, act, exp);
    end
  endtask

  // Timeline model: accept at T, cgo at T+1, response at T+2+L, free again at T+3+L.
  task automatic check_lane(input int k);
    logic [NR-1:0] er;
    bit ecgo, erv, ebusy, done_now, ov;
    int c, p;
    rsp_rec_t r;
    er = '0; ecgo = 1'b0; erv = 1'b0; ebusy = 1'b0; done_now = 1'b0;
    if (!rst_n) begin
      m_busy[k] = 1'b0; m_ptr[k] = 0;
      e_id[k] = 0; e_cnt[k] = 0; e_ovf[k] = 0; e_cn[k] = 0;
    end else if (m_busy[k]) begin
      c = cyc - t_acc[k];
      ebusy = 1'b1;
      if (c == 1) begin
        ecgo = 1'b1;
        e_cn[k] = m_n[k];
      end
      if (c == 2 + m_L[k]) begin
        erv = 1'b1;
        e_id[k] = m_id[k]; e_cnt[k] = m_L[k]; e_ovf[k] = {31'd0, m_ovf[k]};
        m_ptr[k] = (m_id[k] + 1) % NR;
        done_now = 1'b1;
      end
    end else begin
      p = pick(req_valid[k], m_ptr[k]);
      if (p >= 0) begin
        er[p] = 1'b1;
        m_busy[k] = 1'b1;
        t_acc[k] = cyc;
        m_id[k] = p;
        m_n[k] = req_n[k][32*p +: 32];
        m_L[k] = clen(m_n[k], lane_max(k), ov);
        m_ovf[k] = ov;
      end
    end
    chk("req_ready", k, {28'd0, req_ready[k]}, {28'd0, er});
    chk("cgo", k, {31'd0, cgo[k]}, {31'd0, ecgo});
    chk("cn", k, cn[k], e_cn[k]);
    chk("busy", k, {31'd0, busy[k]}, {31'd0, ebusy});
    chk("rsp_valid", k, {31'd0, rsp_valid[k]}, {31'd0, erv});
    chk("rsp_id", k, {30'd0, rsp_id[k]}, e_id[k]);
    chk("rsp_count", k, {16'd0, rsp_count[k]}, e_cnt[k]);
    chk("rsp_ovf", k, {31'd0, rsp_ovf[k]}, e_ovf[k]);
    if (rst_n && rsp_valid[k]) begin
      r.id = int'(rsp_id[k]); r.cnt = int'(rsp_count[k]); r.ov = int'(rsp_ovf[k]);
      r.lat = cyc - t_acc[k];
      lg[k].push_back(r);
    end
    for (int i = 0; i < NR; i++) begin
      if (rst_n && req_ready[k][i]) acc_flag[k*NR+i] = 1'b1;
    end
    if (done_now) m_busy[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NL; k++) check_lane(k);
  end

  // Requester driver: present queue heads, hold until accepted, optionally withdraw.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rst_n) begin
          pend[k*NR+i].delete();
          acc_flag[k*NR+i] = 1'b0;
          req_valid[k][i] = 1'b0;
          req_n[k][32*i +: 32] = '0;
        end else if (acc_flag[k*NR+i]) begin
          acc_flag[k*NR+i] = 1'b0;
          void'(pend[k*NR+i].pop_front());
          req_valid[k][i] = 1'b0;
        end else if (req_valid[k][i] && allow_drop && $urandom_range(0, 15) == 0) begin
          req_valid[k][i] = 1'b0;
        end else if (!req_valid[k][i] && pend[k*NR+i].size() != 0) begin
          req_valid[k][i] = 1'b1;
          req_n[k][32*i +: 32] = pend[k*NR+i][0];
        end
      end
    end
  end

  task automatic submit(input int k, input int i, input int unsigned n);
    pend[k*NR+i].push_back(n);
  endtask

  function automatic bit lane_quiet(input int k);
    if (m_busy[k] || req_valid[k] != '0) return 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (pend[k*NR+i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_done(input int k, input int budget);
    int n;
    n = 0;
    while (!lane_quiet(k)) begin
      @(posedge clk);
      n++;
      if (n > budget) begin
        chk("timeout", k, 32'd1, 32'd0);
        return;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic expect_rsp(input int k, input string nm, input int id, input int cnt,
                            input int ov, input int lat);
    rsp_rec_t r;
    if (lg[k].size() == 0) begin
      chk({nm, "_present"}, k, 32'd0, 32'd1);
      return;
    end
    r = lg[k].pop_front();
    chk({nm, "_id"}, k, r.id, id);
    chk({nm, "_count"}, k, r.cnt, cnt);
    chk({nm, "_ovf"}, k, r.ov, ov);
    chk({nm, "_lat"}, k, r.lat, lat);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int l, sz, guard, k, i;
    int unsigned n;
    bit ov;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    l = clen(27, 65535, ov); chk("pin_len27", 0, l, 112);
    l = clen(6, 65535, ov);  chk("pin_len6", 0, l, 9);
    l = clen(3, 65535, ov);  chk("pin_len3", 0, l, 8);
    l = clen(0, 100, ov);    chk("pin_len0", 1, l, 100); chk("pin_len0_ovf", 1, ov, 1);
    l = pick(4'b1010, 2);    chk("pin_pick_wrap", 0, l, 3);
    l = pick(4'b0011, 3);    chk("pin_pick_wrap0", 0, l, 0);

    // Fairness with ptr at 0 after reset.
    submit(0, 0, 1); submit(0, 1, 2); submit(0, 2, 3); submit(0, 3, 4);
    wait_done(0, 500);
    expect_rsp(0, "fair0", 0, 1, 0, 3);
    expect_rsp(0, "fair1", 1, 2, 0, 4);
    expect_rsp(0, "fair2", 2, 8, 0, 10);
    expect_rsp(0, "fair3", 3, 3, 0, 5);
    submit(0, 1, 1); submit(0, 3, 1);
    wait_done(0, 200);
    expect_rsp(0, "rr_a1", 1, 1, 0, 3);
    expect_rsp(0, "rr_a3", 3, 1, 0, 3);
    submit(0, 1, 1);
    wait_done(0, 200);
    expect_rsp(0, "rr_b1", 1, 1, 0, 3);
    submit(0, 1, 1); submit(0, 3, 1);
    wait_done(0, 200);
    expect_rsp(0, "rr_c3", 3, 1, 0, 3);
    expect_rsp(0, "rr_c1", 1, 1, 0, 3);

    submit(0, 0, 1);  wait_done(0, 200); expect_rsp(0, "single", 0, 1, 0, 3);
    submit(0, 2, 6);  wait_done(0, 200); expect_rsp(0, "short", 2, 9, 0, 11);
    submit(0, 1, 27); wait_done(0, 400); expect_rsp(0, "long", 1, 112, 0, 114);

    submit(1, 0, 0);  wait_done(1, 400); expect_rsp(1, "ovf0", 0, 100, 1, 102);
    submit(1, 0, 1);  wait_done(1, 200); expect_rsp(1, "after_ovf", 0, 1, 0, 3);
    submit(1, 2, 27); wait_done(1, 400); expect_rsp(1, "ovf27", 2, 100, 1, 102);

    // Reset in the middle of a long run: no response, then normal service.
    submit(0, 0, 27);
    guard = 0;
    while (!m_busy[0] && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    chk("rst_launch", 0, {31'd0, m_busy[0]}, 32'd1);
    repeat (20) @(posedge clk);
    sz = lg[0].size();
    do_reset();
    repeat (5) @(posedge clk);
    chk("rst_no_rsp", 0, lg[0].size(), sz);
    submit(0, 3, 6); wait_done(0, 200); expect_rsp(0, "post_rst", 3, 9, 0, 11);

    // Randomised contention with occasional withdrawn requests.
    allow_drop = 1'b1;
    repeat (60) begin
      k = $urandom_range(0, 1);
      i = $urandom_range(0, NR - 1);
      n = (k == 1 && $urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      submit(k, i, n);
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    wait_done(0, 20000);
    wait_done(1, 20000);
    allow_drop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
